// File: rtl/ntt_sched.sv
`default_nettype none
// ============================================================================
// Module   : ntt_sched
// Brief    : NTT/INTT schedule controller. Issues butterfly read addresses,
//            twiddle indices and op codes, and a PIPE-delayed write-back path.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_sched #(
    parameter int LOG_N    = 8,
    parameter int PIPE     = 5,
    parameter int SCALE_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-2:0] tw_addr,
    output logic [1:0]       bf_op,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b,
    output logic [2:0]       layer
);

    localparam int c_HALF = 1 << (LOG_N - 1);
    localparam int c_LL_W = $clog2(LOG_N + 1);
    localparam int c_D_W  = (PIPE > 1) ? $clog2(PIPE) : 1;

    localparam logic [LOG_N-2:0]  c_B_LAST    = '1;
    localparam logic [LOG_N-2:0]  c_B_ONE     = (LOG_N-1)'(1);
    localparam logic [c_D_W-1:0]  c_D_ONE     = c_D_W'(1);
    localparam logic [c_D_W-1:0]  c_D_LAST    = c_D_W'(PIPE - 1);
    localparam logic [2:0]        c_S_LAST    = 3'(LOG_N - 2);
    localparam logic [2:0]        c_LAY_SCALE = 3'(LOG_N - 1);
    localparam logic [LOG_N-1:0]  c_A_ONE     = LOG_N'(1);
    localparam logic [LOG_N-1:0]  c_HALF_A    = LOG_N'(c_HALF);
    localparam logic [c_LL_W-1:0] c_LL_ONE    = c_LL_W'(1);
    localparam logic [c_LL_W-1:0] c_LL_LAST   = c_LL_W'(LOG_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_mode, w_mode_nxt;
    logic             r_scale, w_scale_nxt;
    logic [2:0]       r_s, w_s_nxt;
    logic [LOG_N-2:0] r_b, w_b_nxt;
    logic [c_D_W-1:0] r_d, w_d_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_scale <= 1'b0;
            r_s     <= '0;
            r_b     <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_scale <= w_scale_nxt;
            r_s     <= w_s_nxt;
            r_b     <= w_b_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_scale_nxt = r_scale;
        w_s_nxt     = r_s;
        w_b_nxt     = r_b;
        w_d_nxt     = r_d;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_mode_nxt  = mode;
                    w_scale_nxt = 1'b0;
                    w_s_nxt     = '0;
                    w_b_nxt     = '0;
                    w_d_nxt     = '0;
                end
            end
            S_ISSUE: begin
                w_b_nxt = r_b + c_B_ONE;
                if (r_b == c_B_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_b_nxt     = '0;
                    w_d_nxt     = '0;
                end
            end
            S_DRAIN: begin
                w_d_nxt = r_d + c_D_ONE;
                // Leave DRAIN only once every write of this pass has landed.
                if (r_d == c_D_LAST) begin
                    w_d_nxt = '0;
                    if (!r_scale && (r_s != c_S_LAST)) begin
                        w_s_nxt     = r_s + 3'd1;
                        w_state_nxt = S_ISSUE;
                    end else if (!r_scale && r_mode && (SCALE_EN != 0)) begin
                        w_scale_nxt = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_s_nxt     = '0;
                w_scale_nxt = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Butterfly span is len = 1 << w_ll; group/offset are a shift and a mask.
    logic [c_LL_W-1:0] w_ll;
    logic [LOG_N-1:0]  w_bext, w_len, w_g, w_off, w_pa, w_pb;
    logic [LOG_N-2:0]  w_tw_ntt, w_tw_intt;

    always_comb begin
        w_ll      = r_mode ? (c_LL_W'(r_s) + c_LL_ONE) : (c_LL_LAST - c_LL_W'(r_s));
        w_bext    = {1'b0, r_b};
        w_len     = c_A_ONE << w_ll;
        w_g       = w_bext >> w_ll;
        w_off     = w_bext & (w_len - c_A_ONE);
        w_pa      = ((w_g << w_ll) << 1) | w_off;
        w_pb      = w_pa + w_len;
        w_tw_ntt  = (LOG_N-1)'((c_A_ONE << r_s) + w_g);
        w_tw_intt = (LOG_N-1)'((c_HALF_A >> r_s) - c_A_ONE - w_g);
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        rd_en     = (r_state == S_ISSUE);
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        bf_op     = 2'b00;
        layer     = r_scale ? c_LAY_SCALE : r_s;
        if (rd_en) begin
            if (r_scale) begin
                rd_addr_a = w_bext;
                rd_addr_b = w_bext + c_HALF_A;
                bf_op     = 2'b10;
            end else begin
                rd_addr_a = w_pa;
                rd_addr_b = w_pb;
                tw_addr   = r_mode ? w_tw_intt : w_tw_ntt;
                bf_op     = {1'b0, r_mode};
            end
        end
    end

    // Write-back delay line; shifts in every state so the last pass drains.
    logic             r_dl_en [PIPE];
    logic [LOG_N-1:0] r_dl_a  [PIPE];
    logic [LOG_N-1:0] r_dl_b  [PIPE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE; i++) begin
                r_dl_en[i] <= 1'b0;
                r_dl_a[i]  <= '0;
                r_dl_b[i]  <= '0;
            end
        end else begin
            r_dl_en[0] <= rd_en;
            r_dl_a[0]  <= rd_addr_a;
            r_dl_b[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE; i++) begin
                r_dl_en[i] <= r_dl_en[i-1];
                r_dl_a[i]  <= r_dl_a[i-1];
                r_dl_b[i]  <= r_dl_b[i-1];
            end
        end
    end

    assign wr_en     = r_dl_en[PIPE-1];
    assign wr_addr_a = r_dl_a[PIPE-1];
    assign wr_addr_b = r_dl_b[PIPE-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_sched
// Brief    : Self-checking bench for ntt_sched (defaults, and PIPE=1/no scale).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_start, a_mode, b_start, b_mode;

    logic       a_busy, a_done, a_rd_en, a_wr_en;
    logic [7:0] a_rd_addr_a, a_rd_addr_b, a_wr_addr_a, a_wr_addr_b;
    logic [6:0] a_tw_addr;
    logic [1:0] a_bf_op;
    logic [2:0] a_layer;

    logic       b_busy, b_done, b_rd_en, b_wr_en;
    logic [7:0] b_rd_addr_a, b_rd_addr_b, b_wr_addr_a, b_wr_addr_b;
    logic [6:0] b_tw_addr;
    logic [1:0] b_bf_op;
    logic [2:0] b_layer;

    ntt_sched #(.LOG_N(8), .PIPE(5), .SCALE_EN(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode),
        .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
        .rd_addr_a(a_rd_addr_a), .rd_addr_b(a_rd_addr_b),
        .tw_addr(a_tw_addr), .bf_op(a_bf_op), .wr_en(a_wr_en),
        .wr_addr_a(a_wr_addr_a), .wr_addr_b(a_wr_addr_b), .layer(a_layer)
    );

    ntt_sched #(.LOG_N(8), .PIPE(1), .SCALE_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode),
        .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
        .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b),
        .tw_addr(b_tw_addr), .bf_op(b_bf_op), .wr_en(b_wr_en),
        .wr_addr_a(b_wr_addr_a), .wr_addr_b(b_wr_addr_b), .layer(b_layer)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit a_act = 1'b0, b_act = 1'b0;
    bit a_mm = 1'b0, b_mm = 1'b0;
    int a_s0 = 0, b_s0 = 0;
    int ka, kb;
    int a_wr_cnt, a_done_k, b_done_k, b_op2;
    int pend [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected read issued k cycles after start acceptance, from the schedule rules.
    function automatic bit read_at(input int k, input bit md, input int pp, input bit sc,
                                   output int ea, output int eb, output int et,
                                   output int eo, output int ep);
        int pl, np, r, len, g, off;
        ea = 0; eb = 0; et = 0; eo = 0; ep = 0;
        pl = 128 + pp;
        np = 7 + ((md && sc) ? 1 : 0);
        if (k < 1 || k > np * pl) return 1'b0;
        ep = (k - 1) / pl;
        r  = (k - 1) % pl;
        if (r >= 128) return 1'b0;
        if (ep == 7) begin
            ea = r; eb = r + 128; et = 0; eo = 2;
            return 1'b1;
        end
        len = md ? (2 << ep) : (128 >> ep);
        g   = r / len;
        off = r % len;
        ea  = 2 * g * len + off;
        eb  = ea + len;
        et  = md ? ((128 >> ep) - 1 - g) : ((1 << ep) + g);
        eo  = md ? 1 : 0;
        return 1'b1;
    endfunction

    task automatic cmp(input string tg, input int k, input bit md, input int pp, input bit sc,
                       input logic rd, input logic [7:0] ra, input logic [7:0] rb,
                       input logic [6:0] tw, input logic [1:0] op, input logic [2:0] ly,
                       input logic wr, input logic [7:0] wa, input logic [7:0] wb,
                       input logic bs, input logic dn);
        int ea, eb, et, eo, ep, dc;
        bit er, ew;
        dc = (7 + ((md && sc) ? 1 : 0)) * (128 + pp) + 1;
        er = read_at(k, md, pp, sc, ea, eb, et, eo, ep);
        chk({tg, ".rd_en"}, rd, er);
        if (er) begin
            chk({tg, ".rd_addr_a"}, ra, ea);
            chk({tg, ".rd_addr_b"}, rb, eb);
            chk({tg, ".tw_addr"}, tw, et);
            chk({tg, ".bf_op"}, op, eo);
            chk({tg, ".layer"}, ly, ep);
        end
        ew = read_at(k - pp, md, pp, sc, ea, eb, et, eo, ep);
        chk({tg, ".wr_en"}, wr, ew);
        if (ew) begin
            chk({tg, ".wr_addr_a"}, wa, ea);
            chk({tg, ".wr_addr_b"}, wb, eb);
        end
        chk({tg, ".busy"}, bs, (k >= 1 && k <= dc));
        chk({tg, ".done"}, dn, (k == dc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_rd(input string nm, input int ea, input int eb, input int et, input int eo);
        chk({nm, ".rd_en"}, a_rd_en, 1);
        chk({nm, ".a"}, a_rd_addr_a, ea);
        chk({nm, ".b"}, a_rd_addr_b, eb);
        chk({nm, ".tw"}, a_tw_addr, et);
        chk({nm, ".op"}, a_bf_op, eo);
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_mode = 1'b0; b_start = 1'b0; b_mode = 1'b0;
        fork
            begin : cmp_loop
                forever begin
                    @(negedge clk);
                    if (a_act) begin
                        ka = cyc - a_s0;
                        if (ka == 0) begin
                            a_wr_cnt = 0; a_done_k = -1;
                            foreach (pend[i]) pend[i] = 0;
                        end
                        cmp("A", ka, a_mm, 5, 1'b1, a_rd_en, a_rd_addr_a, a_rd_addr_b,
                            a_tw_addr, a_bf_op, a_layer, a_wr_en, a_wr_addr_a,
                            a_wr_addr_b, a_busy, a_done);
                        if (a_done) a_done_k = ka;
                        if (a_rd_en)
                            chk("A.hazard", (pend[a_rd_addr_a] == 0 && pend[a_rd_addr_b] == 0), 1);
                        if (a_wr_en) begin
                            a_wr_cnt++;
                            pend[a_wr_addr_a]--;
                            pend[a_wr_addr_b]--;
                        end
                        if (a_rd_en) begin
                            pend[a_rd_addr_a]++;
                            pend[a_rd_addr_b]++;
                        end
                    end
                    if (b_act) begin
                        kb = cyc - b_s0;
                        if (kb == 0) begin b_done_k = -1; b_op2 = 0; end
                        cmp("B", kb, b_mm, 1, 1'b0, b_rd_en, b_rd_addr_a, b_rd_addr_b,
                            b_tw_addr, b_bf_op, b_layer, b_wr_en, b_wr_addr_a,
                            b_wr_addr_b, b_busy, b_done);
                        if (b_done) b_done_k = kb;
                        if (b_rd_en && b_bf_op == 2'b10) b_op2++;
                    end
                end
            end
            begin : stim
                int base;
                repeat (3) step();
                chk("rst.busy", a_busy, 0);
                chk("rst.done", a_done, 0);
                chk("rst.rd_en", a_rd_en, 0);
                chk("rst.wr_en", a_wr_en, 0);
                chk("rst.layer", a_layer, 0);
                chk("rst.rd_addr_a", a_rd_addr_a, 0);
                chk("rst.wr_addr_b", a_wr_addr_b, 0);
                chk("rst.tw_addr", a_tw_addr, 0);
                chk("rst.bf_op", a_bf_op, 0);
                chk("rst.b_busy", b_busy, 0);
                rst_n = 1'b1;
                step(); step();

                // Run 1: A = NTT with stray start/mode pulses, B = INTT PIPE=1 no scale
                a_start = 1'b1; a_mode = 1'b0; a_mm = 1'b0; a_s0 = cyc; a_act = 1'b1;
                b_start = 1'b1; b_mode = 1'b1; b_mm = 1'b1; b_s0 = cyc; b_act = 1'b1;
                step();
                a_start = 1'b0; b_start = 1'b0;
                for (int k = 1; k <= 933; k++) begin
                    if (k == 1) lit_rd("ntt.k1", 0, 128, 1, 0);
                    if (k == 2) lit_rd("ntt.k2", 1, 129, 1, 0);
                    if (k == 3) lit_rd("ntt.k3", 2, 130, 1, 0);
                    if (k == 799) lit_rd("ntt.l6a", 0, 2, 64, 0);
                    if (k == 800) lit_rd("ntt.l6b", 1, 3, 64, 0);
                    if (k == 801) lit_rd("ntt.l6c", 4, 6, 65, 0);
                    a_start = (k == 100 || k == 500);
                    a_mode  = (k == 100 || k == 500);
                    if (k == 906) begin
                        chk("B.done_cycle", b_done_k, 904);
                        chk("B.scale_ops", b_op2, 0);
                        b_act = 1'b0;
                    end
                    if (k < 933) step();
                end
                chk("ntt.done_cycle", a_done_k, 932);
                chk("ntt.wr_count", a_wr_cnt, 896);

                // Run 2: INTT started in the IDLE cycle right after done
                a_start = 1'b1; a_mode = 1'b1; a_mm = 1'b1; a_s0 = cyc;
                step();
                a_start = 1'b0; a_mode = 1'b0;
                for (int k = 1; k <= 1066; k++) begin
                    if (k == 1) lit_rd("intt.k1", 0, 2, 127, 1);
                    if (k == 2) lit_rd("intt.k2", 1, 3, 127, 1);
                    if (k == 3) lit_rd("intt.k3", 4, 6, 126, 1);
                    if (k == 799) lit_rd("intt.l6", 0, 128, 1, 1);
                    if (k == 932) begin
                        lit_rd("intt.scale", 0, 128, 0, 2);
                        chk("intt.scale.layer", a_layer, 7);
                    end
                    if (k < 1066) step();
                end
                chk("intt.done_cycle", a_done_k, 1065);
                chk("intt.wr_count", a_wr_cnt, 1024);
                a_act = 1'b0;
                step(); step();

                // Run 3: asynchronous reset mid-run, then restart
                a_start = 1'b1; a_mm = 1'b0; base = cyc; a_s0 = cyc; a_act = 1'b1;
                step();
                a_start = 1'b0;
                while (cyc - base < 300) step();
                chk("prerst.rd_en", a_rd_en, 1);
                a_act = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("arst.busy", a_busy, 0);
                chk("arst.done", a_done, 0);
                chk("arst.rd_en", a_rd_en, 0);
                chk("arst.wr_en", a_wr_en, 0);
                chk("arst.layer", a_layer, 0);
                chk("arst.rd_addr_a", a_rd_addr_a, 0);
                chk("arst.rd_addr_b", a_rd_addr_b, 0);
                chk("arst.wr_addr_a", a_wr_addr_a, 0);
                chk("arst.tw_addr", a_tw_addr, 0);
                chk("arst.bf_op", a_bf_op, 0);
                while (cyc - base < 305) step();
                rst_n = 1'b1;
                while (cyc - base < 310) begin
                    step();
                    chk("postrst.wr_en", a_wr_en, 0);
                    chk("postrst.busy", a_busy, 0);
                end
                a_start = 1'b1; a_mm = 1'b0; a_s0 = cyc; a_act = 1'b1;
                step();
                a_start = 1'b0;
                chk("restart.cycle", cyc - base, 311);
                lit_rd("restart.k1", 0, 128, 1, 0);
                chk("restart.layer", a_layer, 0);
                while (cyc - a_s0 < 933) step();
                chk("restart.done_cycle", a_done_k, 932);
                chk("restart.wr_count", a_wr_cnt, 896);
                a_act = 1'b0;
                step();
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
